cjb_risc_mmio_ctrl: RTL and testbench

Parametrised memory-mapped I/O controller for the cjbRISC processor family. It replaces the fixed single-pushbutton, 4-bit switch, 8-bit LED port with N_IN input channels and N_OUT output channels inside one address window. Each input channel has strobe synchronisation, edge capture, ready/overrun flags and clear-on-read, plus an optional interrupt request. It sits between the datapath's MAR/RW/data buses and the board pins.

---
 rtl/cjb_risc_mmio_ctrl.sv | 161 ++++++++++++++++
 tb/tb_cjb_risc_mmio_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cjb_risc_mmio_ctrl.sv
// cjbRISC MMIO window: synchronised input capture channels plus output
// registers. Optional interrupt logic is enabled by CJB_MMIO_IRQ_EN.
module cjb_risc_mmio_ctrl #(
    parameter int                DATA_W      = 8,
    parameter int                ADDR_W      = 10,
    parameter int                N_IN        = 2,
    parameter int                N_OUT       = 2,
    parameter logic [ADDR_W-1:0] IO_BASE     = 'h3F0,
    parameter int                SYNC_STAGES = 2
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    mem_en,
    input  logic [ADDR_W-1:0]       MAR,
    input  logic                    RW,
    input  logic [DATA_W-1:0]       wr_data,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    rd_valid,
    output logic                    io_sel,
    input  logic [N_IN-1:0]         PB,
    input  logic [N_IN*DATA_W-1:0]  SW,
    output logic [N_OUT*DATA_W-1:0] LEDs,
    output logic                    irq
);

    if (N_IN < 1 || N_IN > 8 || N_OUT < 1 || N_OUT > 8
        || 3 + N_IN + N_OUT > 16 || SYNC_STAGES < 2
        || IO_BASE[3:0] != 4'd0 || DATA_W < N_IN) begin : g_bad_cfg
        $error("cjb_risc_mmio_ctrl: illegal parameter set");
    end

    logic [SYNC_STAGES-1:0][N_IN-1:0]             pb_pipe;
    logic [SYNC_STAGES-1:0][N_IN-1:0][DATA_W-1:0] sw_pipe;
    logic [SYNC_STAGES-1:0]                       fill;
    logic [N_IN-1:0]                              pb_s;
    logic [N_IN-1:0][DATA_W-1:0]                  sw_s;
    logic [N_IN-1:0]                              pb_prev;
    logic [N_IN-1:0]                              armed;
    logic [N_IN-1:0]                              rise;

    logic [N_IN-1:0][DATA_W-1:0]  in_reg;
    logic [N_OUT-1:0][DATA_W-1:0] out_reg;
    logic [N_IN-1:0]              ready;
    logic [N_IN-1:0]              overrun;

    logic [3:0]        off;
    logic              rd_hit;
    logic              wr_hit;
    logic [N_IN-1:0]   rd_clr;
    logic [N_IN-1:0]   ovr_clr;
    logic [DATA_W-1:0] rd_mux;

    assign io_sel = mem_en && (MAR[ADDR_W-1:4] == IO_BASE[ADDR_W-1:4]);
    assign off    = MAR[3:0];
    assign rd_hit = io_sel && RW;
    assign wr_hit = io_sel && !RW;

    assign pb_s = pb_pipe[SYNC_STAGES-1];
    assign sw_s = sw_pipe[SYNC_STAGES-1];
    // A strobe held high through reset must be seen low once before it counts
    assign rise = pb_s & ~pb_prev & armed;
    assign LEDs = out_reg;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            pb_pipe <= '0;
            sw_pipe <= '0;
            fill    <= '0;
            pb_prev <= '0;
            armed   <= '0;
        end else begin
            pb_pipe <= {pb_pipe[SYNC_STAGES-2:0], PB};
            sw_pipe <= {sw_pipe[SYNC_STAGES-2:0], SW};
            fill    <= {fill[SYNC_STAGES-2:0], 1'b1};
            pb_prev <= pb_s;
            armed   <= armed | ({N_IN{fill[SYNC_STAGES-1]}} & ~pb_s);
        end
    end

    always_comb begin
        rd_clr  = '0;
        ovr_clr = '0;
        if (wr_hit && off == 4'd1)
            ovr_clr = wr_data[N_IN-1:0];
        for (int i = 0; i < N_IN; i++)
            if (rd_hit && off == 4'(3 + i))
                rd_clr[i] = 1'b1;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            in_reg  <= '0;
            ready   <= '0;
            overrun <= '0;
        end else begin
            for (int i = 0; i < N_IN; i++)
                if (rise[i])
                    in_reg[i] <= sw_s[i];
            ready   <= (ready & ~rd_clr) | rise;
            overrun <= (overrun & ~ovr_clr) | (rise & ready);
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            out_reg <= '0;
        end else begin
            for (int j = 0; j < N_OUT; j++)
                if (wr_hit && off == 4'(3 + N_IN + j))
                    out_reg[j] <= wr_data;
        end
    end

`ifdef CJB_MMIO_IRQ_EN
    logic [N_IN-1:0] ie;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            ie  <= '0;
            irq <= 1'b0;
        end else begin
            if (wr_hit && off == 4'd2)
                ie <= wr_data[N_IN-1:0];
            irq <= |(ready & ie);
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        if (off == 4'd0)
            rd_mux = DATA_W'(ready);
        if (off == 4'd1)
            rd_mux = DATA_W'(overrun);
`ifdef CJB_MMIO_IRQ_EN
        if (off == 4'd2)
            rd_mux = DATA_W'(ie);
`endif
        for (int i = 0; i < N_IN; i++)
            if (off == 4'(3 + i))
                rd_mux = in_reg[i];
        for (int j = 0; j < N_OUT; j++)
            if (off == 4'(3 + N_IN + j))
                rd_mux = out_reg[j];
    end

    // Out-of-window cycles leave rd_data holding the last read value
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_hit;
            if (rd_hit)
                rd_data <= rd_mux;
        end
    end

endmodule

// File: tb/tb_cjb_risc_mmio_ctrl.sv
// Self-checking bench for cjb_risc_mmio_ctrl with a read-data scoreboard.
// Interrupt expectations follow CJB_MMIO_IRQ_EN.
module tb_cjb_risc_mmio_ctrl;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 10;
    localparam int N_IN   = 2;
    localparam int N_OUT  = 2;
    localparam logic [ADDR_W-1:0] BASE = 10'h3F0;

    logic                    Clock;
    logic                    Reset;
    logic                    mem_en;
    logic [ADDR_W-1:0]       MAR;
    logic                    RW;
    logic [DATA_W-1:0]       wr_data;
    logic [DATA_W-1:0]       rd_data;
    logic                    rd_valid;
    logic                    io_sel;
    logic [N_IN-1:0]         PB;
    logic [N_IN*DATA_W-1:0]  SW;
    logic [N_OUT*DATA_W-1:0] LEDs;
    logic                    irq;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                cyc;
        logic [ADDR_W-1:0] addr;
    } rd_item_t;

    rd_item_t sb[$];
    int cyc;
    int n_checks;
    int n_fail;

    cjb_risc_mmio_ctrl dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .mem_en  (mem_en),
        .MAR     (MAR),
        .RW      (RW),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .io_sel  (io_sel),
        .PB      (PB),
        .SW      (SW),
        .LEDs    (LEDs),
        .irq     (irq)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    // Scoreboard: each read expects rd_valid with its data one edge later
    always @(negedge Clock) begin
        if (rd_valid === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL rd_spurious: rd_valid=1 data=%h, no read pending",
                         rd_data);
            end else begin
                rd_item_t it;
                it = sb.pop_front();
                if (rd_data !== it.data || cyc != it.cyc + 1) begin
                    n_fail++;
                    $display("FAIL rd_%h: got %h at cyc %0d, want %h at cyc %0d",
                             it.addr, rd_data, cyc, it.data, it.cyc + 1);
                end
            end
        end else if (sb.size() > 0 && cyc > sb[0].cyc + 1) begin
            rd_item_t it;
            it = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL rd_missing_%h: rd_valid=%b, want 1 with %h",
                     it.addr, rd_valid, it.data);
        end
    end

    task automatic bus_read(input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] exp);
        rd_item_t it;
        it.data = exp;
        it.cyc  = cyc;
        it.addr = a;
        sb.push_back(it);
        MAR = a;
        RW = 1'b1;
        mem_en = 1'b1;
        @(negedge Clock);
        mem_en = 1'b0;
    endtask

    task automatic bus_write(input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d);
        MAR = a;
        wr_data = d;
        RW = 1'b0;
        mem_en = 1'b1;
        @(negedge Clock);
        mem_en = 1'b0;
    endtask

    task automatic pb_pulse(input int ch, input logic [DATA_W-1:0] d);
        SW[ch*DATA_W +: DATA_W] = d;
        PB[ch] = 1'b1;
        repeat (4) @(negedge Clock);
        PB[ch] = 1'b0;
        repeat (4) @(negedge Clock);
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        PB = '1;
        SW = '1;
        repeat (3) @(negedge Clock);
        n_checks++;
        if (LEDs !== '0 || rd_valid !== 1'b0 || irq !== 1'b0
            || rd_data !== '0) begin
            n_fail++;
            $display("FAIL reset_outs: LEDs=%h rd_valid=%b irq=%b rd=%h, want 0",
                     LEDs, rd_valid, irq, rd_data);
        end
        Reset = 1'b1;
        repeat (6) @(negedge Clock);
        n_checks++;
        if (LEDs !== '0 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: LEDs=%h irq=%b, want 0", LEDs, irq);
        end
        bus_read(BASE + 0, 8'h00);
        PB = '0;
        SW = '0;
        repeat (4) @(negedge Clock);
    endtask

    task automatic test_capture();
        SW[7:0] = 8'hA5;
        PB[0] = 1'b1;
        repeat (2) @(negedge Clock);
        bus_read(BASE + 0, 8'h00);
        bus_read(BASE + 0, 8'h01);
        bus_read(BASE + 3, 8'hA5);
        bus_read(BASE + 0, 8'h00);
        bus_read(BASE + 1, 8'h00);
        repeat (5) @(negedge Clock);
        bus_read(BASE + 0, 8'h00);
        PB[0] = 1'b0;
        repeat (4) @(negedge Clock);
    endtask

    task automatic test_overrun();
        pb_pulse(0, 8'h11);
        pb_pulse(0, 8'h22);
        bus_read(BASE + 1, 8'h01);
        bus_read(BASE + 0, 8'h01);
        bus_read(BASE + 3, 8'h22);
        bus_write(BASE + 1, 8'h01);
        bus_read(BASE + 1, 8'h00);
        bus_read(BASE + 0, 8'h00);
    endtask

    task automatic test_output();
        MAR = BASE + 5;
        wr_data = 8'h3C;
        RW = 1'b0;
        mem_en = 1'b1;
        #1;
        n_checks++;
        if (io_sel !== 1'b1) begin
            n_fail++;
            $display("FAIL io_sel_in: io_sel=%b, want 1", io_sel);
        end
        @(negedge Clock);
        mem_en = 1'b0;
        n_checks++;
        if (LEDs[7:0] !== 8'h3C || LEDs[15:8] !== 8'h00) begin
            n_fail++;
            $display("FAIL led0_write: LEDs=%h, want 003c", LEDs);
        end
        bus_read(BASE + 5, 8'h3C);
        bus_write(BASE + 6, 8'h5A);
        n_checks++;
        if (LEDs !== 16'h5A3C) begin
            n_fail++;
            $display("FAIL led1_write: LEDs=%h, want 5a3c", LEDs);
        end
        MAR = 10'h3EF;
        wr_data = 8'hFF;
        RW = 1'b0;
        mem_en = 1'b1;
        #1;
        n_checks++;
        if (io_sel !== 1'b0) begin
            n_fail++;
            $display("FAIL io_sel_out: io_sel=%b, want 0", io_sel);
        end
        @(negedge Clock);
        RW = 1'b1;
        @(negedge Clock);
        mem_en = 1'b0;
        n_checks++;
        if (LEDs !== 16'h5A3C || rd_valid !== 1'b0 || rd_data !== 8'h3C) begin
            n_fail++;
            $display("FAIL outside: LEDs=%h rdv=%b rd=%h, want 5a3c 0 3c",
                     LEDs, rd_valid, rd_data);
        end
        bus_write(BASE + 15, 8'hEE);
        bus_read(BASE + 15, 8'h00);
        bus_read(BASE + 7, 8'h00);
    endtask

    task automatic test_back_to_back();
        bus_read(BASE + 5, 8'h3C);
        bus_read(BASE + 6, 8'h5A);
        bus_read(BASE + 0, 8'h00);
        bus_read(BASE + 3, 8'h22);
    endtask

    task automatic test_simul_read();
        pb_pulse(0, 8'h11);
        SW[7:0] = 8'h77;
        PB[0] = 1'b1;
        repeat (2) @(negedge Clock);
        bus_read(BASE + 3, 8'h11);
        bus_read(BASE + 0, 8'h01);
        bus_read(BASE + 3, 8'h77);
        bus_read(BASE + 0, 8'h00);
        bus_read(BASE + 1, 8'h01);
        PB[0] = 1'b0;
        repeat (4) @(negedge Clock);
    endtask

    task automatic test_w1c_race();
        pb_pulse(0, 8'h33);
        SW[7:0] = 8'h44;
        PB[0] = 1'b1;
        repeat (2) @(negedge Clock);
        bus_write(BASE + 1, 8'h01);
        bus_read(BASE + 1, 8'h01);
        bus_write(BASE + 1, 8'h01);
        bus_read(BASE + 1, 8'h00);
        bus_read(BASE + 3, 8'h44);
        bus_read(BASE + 0, 8'h00);
        PB[0] = 1'b0;
        repeat (4) @(negedge Clock);
    endtask

    task automatic test_irq();
        logic exp_hi;
`ifdef CJB_MMIO_IRQ_EN
        exp_hi = 1'b1;
        bus_write(BASE + 2, 8'h02);
        bus_read(BASE + 2, 8'h02);
`else
        exp_hi = 1'b0;
        bus_write(BASE + 2, 8'h02);
        bus_read(BASE + 2, 8'h00);
`endif
        SW[15:8] = 8'h99;
        PB[1] = 1'b1;
        repeat (3) @(negedge Clock);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_early: irq=%b, want 0", irq);
        end
        @(negedge Clock);
        n_checks++;
        if (irq !== exp_hi) begin
            n_fail++;
            $display("FAIL irq_rise: irq=%b, want %b", irq, exp_hi);
        end
        PB[1] = 1'b0;
        bus_read(BASE + 4, 8'h99);
        n_checks++;
        if (irq !== exp_hi) begin
            n_fail++;
            $display("FAIL irq_hold: irq=%b, want %b", irq, exp_hi);
        end
        @(negedge Clock);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_fall: irq=%b, want 0", irq);
        end
        bus_read(BASE + 0, 8'h00);
        repeat (4) @(negedge Clock);
    endtask

    task automatic test_reset_abort();
        MAR = BASE + 5;
        wr_data = 8'hFF;
        RW = 1'b0;
        mem_en = 1'b1;
        #2;
        Reset = 1'b0;
        @(negedge Clock);
        mem_en = 1'b0;
        n_checks++;
        if (LEDs !== '0 || rd_valid !== 1'b0 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_abort: LEDs=%h rdv=%b irq=%b, want 0",
                     LEDs, rd_valid, irq);
        end
        Reset = 1'b1;
        repeat (4) @(negedge Clock);
        bus_read(BASE + 5, 8'h00);
        bus_read(BASE + 1, 8'h00);
    endtask

    initial begin
        cyc = 0;
        n_checks = 0;
        n_fail = 0;
        mem_en = 1'b0;
        MAR = '0;
        RW = 1'b0;
        wr_data = '0;
        @(negedge Clock);
        test_reset();
        test_capture();
        test_overrun();
        test_output();
        test_back_to_back();
        test_simul_read();
        test_w1c_race();
        test_irq();
        test_reset_abort();
        repeat (3) @(negedge Clock);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d reads pending, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim time exceeded, want finish");
        $fatal(1, "timeout");
    end

endmodule
